// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file: address width, the XZR index
// and the default datapath width.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_XZR = 5'd31;
  localparam int DATA_W_DEF = 64;
  localparam int REG_SLOTS = 1 << REG_ADDR_W;

  function automatic logic is_xzr(input logic [REG_ADDR_W-1:0] addr);
    return addr == REG_XZR;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// One architectural register: DATA_W flops with load enable and an
// asynchronous active-low clear.
module reg_cell #(
  parameter int DATA_W = 64
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              we_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) q_d = d_i;
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) q_q <= '0;
    else         q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with hard-wired XZR (X31).
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read buses.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = REG_SLOTS
) (
  input  logic                  Clk,
  input  logic                  ResetL,
  input  logic                  RegWr,
  input  logic [REG_ADDR_W-1:0] RA,
  input  logic [REG_ADDR_W-1:0] RB,
  input  logic [REG_ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0]     BusW,
  output logic [DATA_W-1:0]     BusA,
  output logic [DATA_W-1:0]     BusB
);

  // Every address decodes to a slot; slots without storage (XZR, or beyond
  // NREGS) read as constant zero so the read buses are never undefined.
  logic [DATA_W-1:0]    slot_q [REG_SLOTS];
  logic [REG_SLOTS-1:0] we_vec;

  generate
    for (genvar gi = 0; gi < REG_SLOTS; gi++) begin : g_slot
      if (gi < NREGS && gi != int'(REG_XZR)) begin : g_cell
        assign we_vec[gi] = RegWr && (RW == REG_ADDR_W'(gi));
        reg_cell #(
          .DATA_W (DATA_W)
        ) u_cell (
          .Clk    (Clk),
          .ResetL (ResetL),
          .we_i   (we_vec[gi]),
          .d_i    (BusW),
          .q_o    (slot_q[gi])
        );
      end else begin : g_zero
        assign we_vec[gi] = 1'b0;
        assign slot_q[gi] = '0;
      end
    end
  endgenerate

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  assign rd_a = slot_q[RA];
  assign rd_b = slot_q[RB];

`ifdef REGFILE_BYPASS_EN
  // Forward only writes that would actually land in storage, and never while
  // reset is asserted, so XZR and the reset value both still read zero.
  logic wr_live;
  assign wr_live = ResetL && (|we_vec);

  assign BusA = (wr_live && (RW == RA)) ? BusW : rd_a;
  assign BusB = (wr_live && (RW == RB)) ? BusW : rd_b;
`else
  assign BusA = rd_a;
  assign BusB = rd_b;
`endif

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read values,
// a negedge monitor pops and compares them against BusA/BusB.
module tb_register_file;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk    = 1'b0;
  logic        ResetL = 1'b1;
  logic        RegWr  = 1'b0;
  logic [4:0]  RA     = '0;
  logic [4:0]  RB     = '0;
  logic [4:0]  RW     = '0;
  logic [63:0] BusW   = '0;
  logic [63:0] BusA;
  logic [63:0] BusB;

  register_file #(
    .DATA_W (64),
    .NREGS  (32)
  ) dut (
    .Clk    (Clk),
    .ResetL (ResetL),
    .RegWr  (RegWr),
    .RA     (RA),
    .RB     (RB),
    .RW     (RW),
    .BusW   (BusW),
    .BusA   (BusA),
    .BusB   (BusB)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    bit          chk_b;
    bit          chk_alu;
  } vec_t;

  vec_t sb_q[$];
  vec_t mon_v;
  int   vectors_applied = 0;
  int   miscompares     = 0;
  bit   sample_req      = 1'b0;
  logic [63:0] alu_res;
  logic        alu_zero;

  // Monitor: one queued expectation per strobed cycle, sampled mid-cycle.
  always @(negedge Clk) begin
    if (sample_req) begin
      if (sb_q.size() == 0) begin
        $display("FAIL scoreboard_underflow got empty queue required one entry");
        miscompares++;
      end else begin
        mon_v = sb_q.pop_front();
        vectors_applied++;
        $display("vec %-16s RA=%0d RB=%0d BusA=%h BusB=%h", mon_v.name, RA, RB, BusA, BusB);
        if (BusA !== mon_v.exp_a) begin
          $display("FAIL %s BusA got %h required %h", mon_v.name, BusA, mon_v.exp_a);
          miscompares++;
        end
        if (mon_v.chk_b && BusB !== mon_v.exp_b) begin
          $display("FAIL %s BusB got %h required %h", mon_v.name, BusB, mon_v.exp_b);
          miscompares++;
        end
        if (mon_v.chk_alu) begin
          alu_res  = BusA - BusB;
          alu_zero = (alu_res == 64'd0);
          if (alu_res !== 64'd0) begin
            $display("FAIL %s alu_sub got %h required %h", mon_v.name, alu_res, 64'd0);
            miscompares++;
          end
          if (alu_zero !== 1'b1) begin
            $display("FAIL %s alu_zero got %b required 1", mon_v.name, alu_zero);
            miscompares++;
          end
        end
      end
    end
  end

  function automatic logic [63:0] val(input int i);
    return {16'hC0DE, 16'(i), 32'(i * 3 + 1)};
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic expect_v(input string n, input logic [63:0] a, input logic [63:0] b,
                          input bit cb, input bit ca);
    sb_q.push_back('{name: n, exp_a: a, exp_b: b, chk_b: cb, chk_alu: ca});
    sample_req = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    ResetL = 1'b0;
    RegWr  = 1'b1;
    RW     = 5'd4;
    BusW   = '1;
    next_cycle();
    next_cycle();

    // Reset sweep with writes attempted every cycle: reset must win.
    for (int i = 0; i < 32; i++) begin
      next_cycle();
      RA = 5'(i);
      RB = 5'(31 - i);
      RW = 5'(i);
      expect_v($sformatf("reset_rd%0d", i), 64'd0, 64'd0, 1'b1, 1'b0);
    end
    next_cycle();
    ResetL = 1'b1;
    RegWr  = 1'b0;
    RA     = 5'd4;
    RB     = 5'd0;
    expect_v("post_reset", 64'd0, 64'd0, 1'b1, 1'b0);

    for (int i = 0; i < 31; i++) begin
      next_cycle();
      RegWr = 1'b1;
      RW    = 5'(i);
      BusW  = val(i);
    end
    next_cycle();
    RegWr = 1'b0;
    for (int i = 0; i < 31; i++) begin
      next_cycle();
      RA = 5'(i);
      RB = 5'(30 - i);
      expect_v($sformatf("sweep_rd%0d", i), val(i), val(30 - i), 1'b1, 1'b0);
    end

    next_cycle();
    RegWr = 1'b1; RW = 5'd5; BusW = 64'hDEAD_BEEF_0123_4567;
    next_cycle();
    RegWr = 1'b0; BusW = 64'h1111_1111_1111_1111; RA = 5'd5; RB = 5'd5;
    expect_v("wr_rd_x5", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    next_cycle();
    RB = 5'd6;
    expect_v("hold_no_we", 64'hDEAD_BEEF_0123_4567, val(6), 1'b1, 1'b0);

    next_cycle();
    RegWr = 1'b1; RW = 5'd31; BusW = 64'hFFFF_FFFF_FFFF_FFFF; RA = 5'd31; RB = 5'd31;
    expect_v("xzr_wr_cycle", 64'd0, 64'd0, 1'b1, 1'b0);
    next_cycle();
    RegWr = 1'b0;
    expect_v("xzr_after", 64'd0, 64'd0, 1'b1, 1'b0);

    next_cycle();
    RegWr = 1'b1; RW = 5'd7; BusW = 64'd1;
    next_cycle();
    BusW = 64'd2; RA = 5'd7; RB = 5'd8;
    expect_v("hazard_pre", BYP ? 64'd2 : 64'd1, val(8), 1'b1, 1'b0);
    next_cycle();
    RegWr = 1'b0; RB = 5'd7;
    expect_v("hazard_post", 64'd2, 64'd2, 1'b1, 1'b0);

    next_cycle();
    RegWr = 1'b1; RW = 5'd3; BusW = 64'h10;
    next_cycle();
    RegWr = 1'b0; RA = 5'd3; RB = 5'd3;
    expect_v("x3_stored", 64'h10, 64'h10, 1'b1, 1'b0);
    next_cycle();
    ResetL = 1'b0; RegWr = 1'b1; RW = 5'd3; BusW = 64'd9; RB = 5'd7;
    expect_v("midrun_rst", 64'd0, 64'd0, 1'b1, 1'b0);
    next_cycle();
    expect_v("midrun_hold", 64'd0, 64'd0, 1'b1, 1'b0);
    next_cycle();
    ResetL = 1'b1; RegWr = 1'b0;
    expect_v("midrun_lost", 64'd0, 64'd0, 1'b1, 1'b0);
    next_cycle();
    RegWr = 1'b1; RB = 5'd3;
    expect_v("first_wr_pre", BYP ? 64'd9 : 64'd0, BYP ? 64'd9 : 64'd0, 1'b1, 1'b0);
    next_cycle();
    RegWr = 1'b0;
    expect_v("first_wr_post", 64'd9, 64'd9, 1'b1, 1'b0);

    next_cycle();
    RegWr = 1'b1; RW = 5'd1; BusW = 64'd6;
    next_cycle();
    RW = 5'd2;
    next_cycle();
    RegWr = 1'b0; RA = 5'd1; RB = 5'd2;
    expect_v("alu_sub", 64'd6, 64'd6, 1'b1, 1'b1);

    next_cycle();
    for (int k = 0; k < 5 && sb_q.size() != 0; k++) @(negedge Clk);
    if (sb_q.size() != 0) begin
      $display("FAIL drain got %0d pending required 0", sb_q.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
